// File: rtl/micro_dispatch.sv
// Instruction dispatcher: buffers up to two opcodes and hands them one at a time
// to a microcode unit with an sos/eos handshake, with halt and timeout traps.
module micro_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [5:0]  HALT_OPCODE    = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [5:0]  opcode,
   output logic        sos,
   input  logic        eos,
   output logic        busy,
   output logic        halted,
   output logic        timeout,
   output logic [15:0] retired
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DISPATCH = 3'd1;
   localparam logic [2:0] S_WAIT     = 3'd2;
   localparam logic [2:0] S_HALT     = 3'd3;
   localparam logic [2:0] S_TIMEOUT  = 3'd4;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [5:0]  buf0, buf1;
   logic [1:0]  count;
   logic [15:0] wait_cnt;
   logic [5:0]  in_op, head_op;
   logic        accept, head_valid, pop;
   logic        unused_instr;

   assign in_op        = instr[31:26];
   assign unused_instr = ^instr[25:0];

   assign instr_ready = !rst && (count != 2'd2) && (state != S_HALT) && (state != S_TIMEOUT);
   assign accept      = instr_valid && instr_ready;

   // In IDLE with an empty buffer the incoming opcode bypasses storage for 1-cycle latency
   assign head_valid = (count != 2'd0) || ((state == S_IDLE) && accept);
   assign head_op    = (count != 2'd0) ? buf0 : in_op;
   assign pop        = head_valid && ((state == S_IDLE) || ((state == S_WAIT) && eos));

   assign sos     = (state == S_DISPATCH);
   assign busy    = (state == S_DISPATCH) || (state == S_WAIT);
   assign halted  = (state == S_HALT);
   assign timeout = (state == S_TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         buf0     <= '0;
         buf1     <= '0;
         count    <= '0;
         wait_cnt <= '0;
         opcode   <= '0;
         retired  <= '0;
      end else begin
         if (pop && accept) begin
            if (count != 2'd0)
               buf0 <= in_op;
         end else if (pop) begin
            buf0  <= buf1;
            count <= count - 2'd1;
         end else if (accept) begin
            if (count == 2'd0)
               buf0 <= in_op;
            else
               buf1 <= in_op;
            count <= count + 2'd1;
         end

         case (state)
            S_IDLE: begin
               if (pop) begin
                  opcode   <= head_op;
                  wait_cnt <= '0;
                  state    <= (head_op == HALT_OPCODE) ? S_HALT : S_DISPATCH;
               end
            end
            S_DISPATCH: state <= S_WAIT;
            S_WAIT: begin
               if (eos) begin
                  retired <= retired + 16'd1;
                  if (pop) begin
                     opcode   <= head_op;
                     wait_cnt <= '0;
                     state    <= (head_op == HALT_OPCODE) ? S_HALT : S_DISPATCH;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= S_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_micro_dispatch.sv
// Bench for micro_dispatch: fixed vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_micro_dispatch;

   localparam int         T    = 4;
   localparam logic [5:0] HALT = 6'h3F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        eos = 1'b0;
   logic        instr_ready, sos, busy, halted, timeout;
   logic [5:0]  opcode;
   logic [15:0] retired;

   micro_dispatch #(.TIMEOUT_CYCLES(T), .HALT_OPCODE(HALT)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .opcode(opcode), .sos(sos), .eos(eos),
      .busy(busy), .halted(halted), .timeout(timeout), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending opcodes in a queue plus segment progress flags
   logic [5:0]  mq[$];
   bit          m_sos, m_wait, m_halt, m_tout;
   int          m_waited;
   logic [15:0] m_ret;
   logic [5:0]  m_op;

   typedef struct {
      bit          v;
      logic [5:0]  op;
      bit          e;
      logic [31:0] expv;
   } vec_t;
   vec_t vecs[14];

   function automatic logic [31:0] pk(bit rdy, bit s, bit b, bit h, bit t,
                                      logic [5:0] op, logic [15:0] r);
      return {5'b0, rdy, s, b, h, t, op, r};
   endfunction

   function automatic logic [31:0] dut_vec();
      return pk(instr_ready, sos, busy, halted, timeout, opcode, retired);
   endfunction

   function automatic bit m_ready();
      return !m_halt && !m_tout && (mq.size() < 2);
   endfunction

   function automatic logic [31:0] model_vec();
      return pk(m_ready(), m_sos, m_sos || m_wait, m_halt, m_tout, m_op, m_ret);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, expv);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_sos = 0; m_wait = 0; m_halt = 0; m_tout = 0;
      m_waited = 0; m_ret = '0; m_op = '0;
   endtask

   task automatic m_start(input logic [5:0] o);
      m_op = o;
      if (o == HALT) m_halt = 1;
      else           m_sos  = 1;
   endtask

   task automatic model_update(input bit v, input logic [5:0] op, input bit e);
      bit acc;
      acc = v && m_ready();
      if (m_halt || m_tout) return;
      if (m_sos) begin
         m_sos = 0; m_wait = 1; m_waited = 0;
         if (acc) mq.push_back(op);
      end else if (m_wait) begin
         if (e) begin
            m_ret  = m_ret + 16'd1;
            m_wait = 0;
            if (mq.size() > 0) m_start(mq.pop_front());
         end else begin
            m_waited++;
            if (m_waited == T) begin
               m_wait = 0;
               m_tout = 1;
            end
         end
         if (acc) mq.push_back(op);
      end else begin
         if (acc) mq.push_back(op);
         if (mq.size() > 0) m_start(mq.pop_front());
      end
   endtask

   // Called at posedge+1; returns at the following posedge+1
   task automatic step(input bit v, input logic [5:0] op, input bit e, input string tag,
                       input bit use_exp = 0, input logic [31:0] expv = '0);
      instr_valid = v;
      instr       = {op, 26'($urandom)};
      eos         = e;
      @(negedge clk);
      if (use_exp) check({tag, "_row"}, dut_vec(), expv);
      check({tag, "_model"}, dut_vec(), model_vec());
      model_update(v, op, e);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input string tag);
      instr_valid = 0;
      eos = 0;
      rst = 1;
      #1;
      check({tag, "_async_reset"}, dut_vec(), pk(0, 0, 0, 0, 0, 6'h00, 16'h0000));
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((m_sos || m_wait || mq.size() > 0) && !m_halt && !m_tout && n < 50) begin
         step(0, 6'h00, m_wait, tag);
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_bound: drain still active after %0d cycles, required idle", tag, n);
      end
   endtask

   initial begin
      // single instruction, then two back-to-back; eos during DISPATCH must be ignored
      vecs[0]  = '{1'b1, 6'h23, 1'b0, pk(1, 0, 0, 0, 0, 6'h00, 16'd0)};
      vecs[1]  = '{1'b0, 6'h00, 1'b1, pk(1, 1, 1, 0, 0, 6'h23, 16'd0)};
      vecs[2]  = '{1'b0, 6'h00, 1'b0, pk(1, 0, 1, 0, 0, 6'h23, 16'd0)};
      vecs[3]  = '{1'b0, 6'h00, 1'b0, pk(1, 0, 1, 0, 0, 6'h23, 16'd0)};
      vecs[4]  = '{1'b0, 6'h00, 1'b1, pk(1, 0, 1, 0, 0, 6'h23, 16'd0)};
      vecs[5]  = '{1'b0, 6'h00, 1'b0, pk(1, 0, 0, 0, 0, 6'h23, 16'd1)};
      vecs[6]  = '{1'b1, 6'h23, 1'b0, pk(1, 0, 0, 0, 0, 6'h23, 16'd1)};
      vecs[7]  = '{1'b1, 6'h2B, 1'b1, pk(1, 1, 1, 0, 0, 6'h23, 16'd1)};
      vecs[8]  = '{1'b0, 6'h00, 1'b0, pk(1, 0, 1, 0, 0, 6'h23, 16'd1)};
      vecs[9]  = '{1'b0, 6'h00, 1'b1, pk(1, 0, 1, 0, 0, 6'h23, 16'd1)};
      vecs[10] = '{1'b0, 6'h00, 1'b0, pk(1, 1, 1, 0, 0, 6'h2B, 16'd2)};
      vecs[11] = '{1'b0, 6'h00, 1'b0, pk(1, 0, 1, 0, 0, 6'h2B, 16'd2)};
      vecs[12] = '{1'b0, 6'h00, 1'b1, pk(1, 0, 1, 0, 0, 6'h2B, 16'd2)};
      vecs[13] = '{1'b0, 6'h00, 1'b0, pk(1, 0, 0, 0, 0, 6'h2B, 16'd3)};

      @(posedge clk);
      #1;
      apply_reset("por");

      for (int i = 0; i < 14; i++)
         step(vecs[i].v, vecs[i].op, vecs[i].e, $sformatf("tbl%0d", i), 1, vecs[i].expv);

      // buffer full while WAIT stalls
      step(1, 6'h01, 0, "full_c0");
      step(1, 6'h02, 0, "full_c1");
      step(1, 6'h03, 0, "full_c2");
      check("full_ready_low_a", 32'(instr_ready), 32'd0);
      step(1, 6'h04, 0, "full_c3");
      check("full_ready_low_b", 32'(instr_ready), 32'd0);
      step(1, 6'h04, 1, "full_c4");
      check("full_ready_rise", 32'({instr_ready, sos}), 32'b11);
      step(1, 6'h04, 0, "full_c5");
      drain("full_drain");

      // asynchronous reset mid-segment with both entries held
      step(1, 6'h07, 0, "mid_c0");
      step(1, 6'h08, 0, "mid_c1");
      step(1, 6'h09, 0, "mid_c2");
      check("mid_pre_reset", 32'({busy, instr_ready}), 32'b10);
      apply_reset("mid");
      for (int i = 0; i < 3; i++) step(0, 6'h00, 0, "mid_post");
      check("mid_post_empty", 32'({instr_ready, sos, busy, retired}), {13'd0, 3'b100, 16'd0});

      // halt queued behind a normal opcode
      step(1, 6'h23, 0, "halt_c0");
      step(1, HALT,  0, "halt_c1");
      step(1, 6'h11, 0, "halt_c2");
      step(1, 6'h11, 1, "halt_c3");
      check("halt_retired", 32'(retired), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check("halt_terminal", 32'({halted, instr_ready, sos}), 32'b100);
         step(1, 6'h11, 1'($urandom), "halt_hold");
      end
      apply_reset("halt");

      // timeout after T WAIT cycles without eos
      step(1, 6'h05, 0, "tmo_c0");
      step(0, 6'h00, 0, "tmo_disp");
      for (int i = 0; i < T - 1; i++) step(0, 6'h00, 0, "tmo_wait");
      check("tmo_not_yet", 32'({timeout, busy}), 32'b01);
      step(0, 6'h00, 0, "tmo_last");
      check("tmo_flag", 32'({timeout, busy, instr_ready}), 32'b100);
      step(1, 6'h06, 1, "tmo_hold");
      apply_reset("tmo");

      // eos on the final allowed WAIT cycle wins over the timeout
      step(1, 6'h05, 0, "eosw_c0");
      step(0, 6'h00, 0, "eosw_disp");
      for (int i = 0; i < T - 1; i++) step(0, 6'h00, 0, "eosw_wait");
      step(0, 6'h00, 1, "eosw_last");
      check("eosw_retire", 32'({timeout, busy, retired}), 32'd1);
      apply_reset("eosw");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit v, e;
         logic [5:0] op;
         if (m_halt || m_tout) apply_reset("rnd");
         v  = 1'($urandom_range(0, 1));
         op = ($urandom_range(0, 199) == 0) ? HALT : 6'($urandom_range(0, 62));
         if (m_wait && m_waited == T - 1) e = ($urandom_range(0, 7) != 0);
         else                             e = ($urandom_range(0, 2) == 0);
         step(v, op, e, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/micro_dispatch.md
MICRO_DISPATCH -- requirements
Module: micro_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles allowed from an sos pulse to eos before a timeout is flagged (range 1..65535).
REQ-002 Parameter HALT_OPCODE, default 6'h3F: the opcode value that stops dispatch permanently.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port instr, input, 32 bits: the instruction word; opcode is bits 31:26.
REQ-006 Port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-007 Port instr_ready, output, 1 bit: the block accepts instr this cycle.
REQ-008 Port opcode, output, 6 bits: opcode presented to the microcode unit.
REQ-009 Port sos, output, 1 bit: start-of-segment pulse to the microcode unit.
REQ-010 Port eos, input, 1 bit: end-of-segment from the microcode unit.
REQ-011 Port busy, output, 1 bit: a segment is in flight (DISPATCH or WAIT).
REQ-012 Port halted, output, 1 bit: HALT state reached; sticky until reset.
REQ-013 Port timeout, output, 1 bit: TIMEOUT state reached; sticky until reset.
REQ-014 Port retired, output, 16 bits: count of completed segments.

Function
REQ-015 The block SHALL implement a 2-entry instruction buffer holding the opcode only; instr_ready = 1 when fewer than 2 entries are held and the state is not HALT or TIMEOUT.
REQ-016 An accept SHALL occur when instr_valid && instr_ready; the buffer SHALL accept and pop in the same cycle when 1 entry is held, with no bubble.
REQ-017 The FSM SHALL have states IDLE, DISPATCH, WAIT, HALT and TIMEOUT.
REQ-018 IDLE -> DISPATCH when the buffer is non-empty and the head opcode != HALT_OPCODE; the head is popped into the opcode register.
REQ-019 IDLE -> HALT when the head opcode == HALT_OPCODE; that entry is popped and opcode is driven to HALT_OPCODE.
REQ-020 DISPATCH SHALL last exactly 1 cycle with sos = 1, then go to WAIT; sos SHALL be 0 in every other state.
REQ-021 eos SHALL be ignored during DISPATCH, because a stale eos from the previous segment may still be high.
REQ-022 In WAIT, eos = 1 SHALL trigger the following in the same edge:
  - retired increments by 1 (wraps 16'hFFFF -> 0);
  - if the buffer is non-empty with a non-halt head, go to DISPATCH (back-to-back, no IDLE cycle);
  - else if the head is HALT_OPCODE, go to HALT;
  - else go to IDLE.
REQ-023 A WAIT cycle counter SHALL clear on entry to DISPATCH and increment each WAIT cycle without eos.
REQ-024 When the WAIT cycle counter reaches TIMEOUT_CYCLES with eos = 0, the FSM SHALL go to TIMEOUT.
REQ-025 If eos arrives in the same cycle the counter reaches TIMEOUT_CYCLES, eos SHALL win and the segment retires.
REQ-026 HALT and TIMEOUT SHALL be terminal until reset; instr_valid is ignored in both.
REQ-027 opcode SHALL hold its last dispatched value in IDLE, WAIT, HALT and TIMEOUT.
REQ-028 busy = 1 exactly in DISPATCH and WAIT.
REQ-029 Dispatch latency SHALL be 1 cycle: an instruction accepted in IDLE with an empty buffer drives sos on the next cycle.

Reset
REQ-030 While rst = 1 the block SHALL asynchronously force the following, taking effect immediately (including mid-segment):
  - state IDLE, buffer empty, counters 0;
  - opcode = 0, sos = 0, busy = 0, halted = 0, timeout = 0, retired = 0;
  - instr_ready = 0.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Single instruction: reset, instr = 32'h8C000000 valid 1 cycle, eos high 3 cycles after sos -> opcode = 6'h23, one sos pulse, busy 4 cycles, retired = 1, state IDLE.
REQ-033 Back-to-back: opcodes 6'h23 and 6'h2B queued, eos each 2 cycles after sos -> second sos exactly 1 cycle after the first eos, retired = 2.
REQ-034 Buffer full: 3 valid instructions presented while WAIT stalls -> instr_ready drops after 2 accepts and rises the cycle the first entry pops.
REQ-035 Halt: opcode 6'h3F queued after 6'h23 -> 6'h23 retires, halted = 1, instr_ready = 0, no further sos even with instr_valid held high.
REQ-036 Timeout: TIMEOUT_CYCLES = 4, eos held 0 -> timeout = 1 on the 4th WAIT cycle; a repeat run with eos on that exact cycle -> retire instead, timeout = 0.
REQ-037 Reset mid-segment: assert rst in WAIT with 2 entries buffered -> all outputs reach reset values without a clock edge; after deassert, buffer is empty and retired = 0.
